// File: rtl/mchan_arb_cmd_queue_ipa.sv
// In-order command/ID queue between the MCHAN request arbiter and the command consumer.
// One cycle fall-through with no bypass; gnt_o drops while the queue is full and never depends on req_i or gnt_i.
module mchan_arb_cmd_queue_ipa #(
  parameter int DATA_WIDTH = 32,
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_mem_q   [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push, pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign gnt_o         = !rst && (count_q != CNT_WIDTH'(DEPTH));
  assign req_o         = (count_q != '0);
  assign push          = req_i && gnt_o;
  assign pop           = req_o && gnt_i;
  assign data_o        = req_o ? data_mem_q[rd_ptr_q] : '0;
  assign id_o          = req_o ? id_mem_q[rd_ptr_q] : '0;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CNT_WIDTH'(AF_LEVEL));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= data_i;
      id_mem_q[wr_ptr_q]   <= id_i;
    end
  end

endmodule

// File: tb/tb_mchan_arb_cmd_queue_ipa.sv
// Bench for mchan_arb_cmd_queue_ipa: a DEPTH=4 and a DEPTH=3 instance checked against queue models.
module tb_mchan_arb_cmd_queue_ipa;

  localparam int DW = 32;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_req_i, a_gnt_o, a_req_o, a_gnt_i, a_af_o;
  logic [DW-1:0] a_data_i, a_data_o;
  logic [IW-1:0] a_id_i, a_id_o;
  logic [2:0]    a_count_o;

  logic          b_req_i, b_gnt_o, b_req_o, b_gnt_i, b_af_o;
  logic [DW-1:0] b_data_i, b_data_o;
  logic [IW-1:0] b_id_i, b_id_o;
  logic [1:0]    b_count_o;

  mchan_arb_cmd_queue_ipa #(.DATA_WIDTH(DW), .N_MASTER(2), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_i(a_req_i), .gnt_o(a_gnt_o), .data_i(a_data_i), .id_i(a_id_i),
    .req_o(a_req_o), .gnt_i(a_gnt_i), .data_o(a_data_o), .id_o(a_id_o),
    .count_o(a_count_o), .almost_full_o(a_af_o)
  );

  mchan_arb_cmd_queue_ipa #(.DATA_WIDTH(DW), .N_MASTER(2), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_i(b_req_i), .gnt_o(b_gnt_o), .data_i(b_data_i), .id_i(b_id_i),
    .req_o(b_req_o), .gnt_i(b_gnt_i), .data_o(b_data_o), .id_o(b_id_o),
    .count_o(b_count_o), .almost_full_o(b_af_o)
  );

  // Reference queues, entries are {id, data}.
  logic [DW+IW-1:0] qa[$];
  logic [DW+IW-1:0] qb[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare every output of both instances against the models, then clock once.
  task automatic cyc(input string tag);
    logic [DW+IW-1:0] ha, hb;
    logic pa, pb, oa, ob;
    #1;
    ha = (qa.size() != 0) ? qa[0] : '0;
    hb = (qb.size() != 0) ? qb[0] : '0;
    check({tag, ":a_gnt"},   a_gnt_o,   64'(!rst && qa.size() != 4));
    check({tag, ":a_req"},   a_req_o,   64'(qa.size() != 0));
    check({tag, ":a_data"},  a_data_o,  64'(ha[DW-1:0]));
    check({tag, ":a_id"},    a_id_o,    64'(ha[DW]));
    check({tag, ":a_count"}, a_count_o, 64'(qa.size()));
    check({tag, ":a_af"},    a_af_o,    64'(qa.size() >= 3));
    check({tag, ":b_gnt"},   b_gnt_o,   64'(!rst && qb.size() != 3));
    check({tag, ":b_req"},   b_req_o,   64'(qb.size() != 0));
    check({tag, ":b_data"},  b_data_o,  64'(hb[DW-1:0]));
    check({tag, ":b_id"},    b_id_o,    64'(hb[DW]));
    check({tag, ":b_count"}, b_count_o, 64'(qb.size()));
    check({tag, ":b_af"},    b_af_o,    64'(qb.size() >= 2));
    pa = !rst && a_req_i && (qa.size() != 4);
    pb = !rst && b_req_i && (qb.size() != 3);
    oa = (qa.size() != 0) && a_gnt_i;
    ob = (qb.size() != 0) && b_gnt_i;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) qa.delete(0);
      if (ob) qb.delete(0);
      if (pa) qa.push_back({a_id_i, a_data_i});
      if (pb) qb.push_back({b_id_i, b_data_i});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_req_i = 0; a_gnt_i = 0; a_data_i = '0; a_id_i = '0;
    b_req_i = 0; b_gnt_i = 0; b_data_i = '0; b_id_i = '0;
    @(posedge clk);
    #1;

    // Reset held: grant forced low.
    #1;
    check("rst_gnt_a", a_gnt_o, 0);
    check("rst_gnt_b", b_gnt_o, 0);
    cyc("rst_hold");
    rst = 1'b0;
    #1;
    check("idle_gnt", a_gnt_o, 1);
    check("idle_data", a_data_o, 0);
    cyc("idle");

    // Fill DEPTH=4 with gnt_i low.
    for (int i = 0; i < 4; i++) begin
      a_req_i = 1; a_data_i = 32'hA0 + 32'(i); a_id_i = IW'(i % 2);
      cyc("fill");
      check("fill_count", a_count_o, 64'(i + 1));
      check("fill_af", a_af_o, 64'(i + 1 >= 3));
    end
    a_data_i = 32'hA4; a_id_i = 0;
    #1;
    check("full_gnt", a_gnt_o, 0);
    cyc("fifth_req");
    check("fifth_count", a_count_o, 4);

    // Pop from full with req_i still held.
    a_gnt_i = 1;
    #1;
    check("popfull_gnt", a_gnt_o, 0);
    check("popfull_data", a_data_o, 32'hA0);
    check("popfull_id", a_id_o, 0);
    cyc("popfull");
    a_gnt_i = 0; a_req_i = 0;
    #1;
    check("after_pop_gnt", a_gnt_o, 1);
    check("after_pop_count", a_count_o, 3);
    check("after_pop_data", a_data_o, 32'hA1);
    check("after_pop_id", a_id_o, 1);

    // Drain, then fall-through latency from empty.
    a_gnt_i = 1;
    for (int i = 0; i < 3; i++) cyc("drain");
    a_req_i = 1; a_data_i = 32'h55; a_id_i = 1;
    #1;
    check("ft_req_n", a_req_o, 0);
    cyc("ft_push");
    a_req_i = 0;
    #1;
    check("ft_req_n1", a_req_o, 1);
    check("ft_data_n1", a_data_o, 32'h55);
    check("ft_id_n1", a_id_o, 1);
    cyc("ft_pop");
    check("ft_count_n2", a_count_o, 0);

    // Streaming at count 1 on both instances: 20 commands each.
    a_gnt_i = 0; b_gnt_i = 0;
    a_req_i = 1; a_data_i = $urandom; a_id_i = IW'($urandom);
    b_req_i = 1; b_data_i = $urandom; b_id_i = IW'($urandom);
    cyc("stream_prime");
    a_gnt_i = 1; b_gnt_i = 1;
    for (int i = 0; i < 20; i++) begin
      a_data_i = $urandom; a_id_i = IW'($urandom);
      b_data_i = $urandom; b_id_i = IW'($urandom);
      cyc("stream");
      check("stream_count_a", a_count_o, 1);
      check("stream_count_b", b_count_o, 1);
    end
    a_req_i = 0; b_req_i = 0;
    cyc("stream_drain");

    // Reset mid-stream with three entries queued.
    a_gnt_i = 0; b_gnt_i = 0;
    a_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      a_data_i = 32'hC0 + 32'(i); a_id_i = IW'(i % 2);
      cyc("prefill");
    end
    rst = 1;
    cyc("mid_rst");
    rst = 0; a_data_i = 32'h77; a_id_i = 0;
    #1;
    check("rst_count", a_count_o, 0);
    check("rst_req", a_req_o, 0);
    cyc("post_rst_push");
    a_req_i = 0;
    #1;
    check("post_rst_head", a_data_o, 32'h77);
    check("post_rst_req", a_req_o, 1);
    cyc("post_rst_idle");

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      a_req_i = $urandom_range(0, 3) != 0; a_gnt_i = $urandom_range(0, 2) != 0;
      a_data_i = $urandom; a_id_i = IW'($urandom);
      b_req_i = $urandom_range(0, 1) != 0; b_gnt_i = $urandom_range(0, 3) == 0;
      b_data_i = $urandom; b_id_i = IW'($urandom);
      cyc("rand");
    end
    rst = 0;
    a_req_i = 0; b_req_i = 0;
    cyc("final");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mchan_arb_cmd_queue_ipa.md
Name: mchan_arb_cmd_queue_ipa

Overview:
- Command buffer directly downstream of the MCHAN request arbiter.
- Accepts the arbitrated command word and its master ID through the arbiter's req/gnt output handshake.
- Stores up to DEPTH commands in order and presents them to the downstream consumer (TCDM/ext command unit) through the same req/gnt protocol.
- Decouples the arbiter from downstream stalls. The ID travels with each entry so responses can be routed back to the originating master.

Parameters:
- DATA_WIDTH, 32: width of the command word.
- N_MASTER, 2: number of arbitrated masters.
- ID_WIDTH, $clog2(N_MASTER) (minimum 1): width of the master ID carried with each entry.
- DEPTH, 4: number of entries. Legal range is ≥2; non-power-of-two values are allowed.
- AF_LEVEL, DEPTH-1: occupancy at or above which almost_full_o asserts. Legal range is 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk, in, 1: clock. All state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_i, in, 1: arbiter has a valid command.
- gnt_o, out, 1: queue accepts the command this cycle.
- data_i, in, DATA_WIDTH: arbitrated command word.
- id_i, in, ID_WIDTH: master ID of data_i.
- req_o, out, 1: head entry is valid.
- gnt_i, in, 1: consumer takes the head entry this cycle.
- data_o, out, DATA_WIDTH: head command word.
- id_o, out, ID_WIDTH: head master ID.
- count_o, out, CNT_WIDTH: current occupancy.
- almost_full_o, out, 1: count_o ≥ AF_LEVEL.

Behaviour:
- State:
  - Storage array of DEPTH entries, each {data, id}.
  - wr_ptr and rd_ptr, each 0..DEPTH-1.
  - count, 0..DEPTH.
  - Storage array is not reset; pointers and count are.
- Reset:
  - While rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0.
  - Consequences after reset: req_o=0, count_o=0, almost_full_o=0, data_o=0, id_o=0.
  - While rst is high: gnt_o=0, combinationally.
  - Reset mid-operation discards all entries. No pop is reported for discarded entries.
- Push:
  - gnt_o = !rst && (count != DEPTH).
  - gnt_o depends only on registered state. There is no combinational path from req_i or gnt_i to gnt_o.
  - A push occurs when req_i && gnt_o. {data_i, id_i} is written at wr_ptr, and wr_ptr advances.
- Pop:
  - req_o = (count != 0).
  - data_o and id_o = entry[rd_ptr] when req_o=1, else all zeros.
  - A pop occurs when req_o && gnt_i, and rd_ptr advances.
  - gnt_i while req_o=0 is ignored.
- Pointer wrap: on advance, a pointer equal to DEPTH-1 returns to 0. This holds for any DEPTH, not only powers of two.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push+pop, or when neither occurs.
- Latency:
  - No bypass. A command pushed in cycle N is first visible on req_o/data_o/id_o in cycle N+1.
  - Minimum fall-through latency is 1 cycle.
  - Sustained throughput is 1 command/cycle when the consumer holds gnt_i=1 and 0<count<DEPTH.
- Full (count=DEPTH):
  - gnt_o=0, even if gnt_i=1 in the same cycle (no full-pass-through).
  - If a pop occurs in that cycle, gnt_o returns to 1 in the next cycle.
- Empty (count=0): req_o=0. A push into an empty queue does not make req_o=1 in the same cycle.
- Stability:
  - While req_o=1 and gnt_i=0, data_o, id_o and req_o hold constant.
  - This holds independently of pushes into the queue.
- Ordering: strict FIFO. The id travels unchanged with its data.
- almost_full_o is registered-equivalent, derived from count only.
- Input protocol: the arbiter may drop req_i without a grant. The queue samples only on req_i && gnt_o.

Test Plan:
- Reset, then idle → req_o=0, gnt_o=1, count_o=0, data_o=0, id_o=0. With rst=1 held, gnt_o=0.
- DEPTH=4, push 0xA0..0xA3 with ids 0,1,0,1 and gnt_i=0 → count_o steps 1..4; almost_full_o rises at count_o=3; gnt_o=0 at count_o=4. A 5th req_i held is not accepted and count_o stays 4.
- From full, gnt_i=1 for one cycle with req_i=1 held → in the pop cycle gnt_o=0 and data_o=0xA0, id_o=0. Next cycle gnt_o=1, count_o=3, head becomes 0xA1/id 1.
- Empty queue, push 0x55/id 1 in cycle N with gnt_i=1 held → req_o=0 in cycle N; req_o=1 with data_o=0x55, id_o=1 in N+1; count_o returns to 0 in N+2.
- Continuous req_i and gnt_i=1 over 20 commands at count_o=1 → one command accepted and one delivered per cycle; count_o stays 1; output order and ids match input. Pointers wrap at least 4 times; repeat with DEPTH=3 for non-power-of-two wrap.
- Fill 3 entries, assert rst for one cycle mid-stream → next cycle count_o=0, req_o=0. Next pushed command 0x77 appears as head with no stale data.
